iram_loader: RTL
================

Name: iram_loader

Overview:
- Instruction-RAM responder on the far side of the program counter's fetch interface.
- Holds the program store, which is filled at boot from a host byte stream.
- Returns the 16-bit instruction word for the presented IRAM_address with one cycle of registered read latency.
- Gates the CPU through cpu_enable until a complete program has been loaded.

Parameters:
ADDR_WIDTH, 8, fetch/write address width
DATA_WIDTH, 16, instruction word width (fixed at 2 bytes per word)
DEPTH, 256, number of instruction words (2**ADDR_WIDTH)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
IRAM_address  input  8  fetch address from the program counter
instruction  output  16  registered instruction word for the previous cycle's IRAM_address
load_start  input  1  pulse: enter LOAD and clear the write pointer
load_valid  input  1  load_byte is valid this cycle
load_byte  input  8  program byte, low byte first then high byte of each word
load_end  input  1  pulse: finish loading and enter RUN
cpu_enable  output  1  high only in RUN; the CPU/PC must hold while low
load_count  output  9  number of words committed in the current load
load_error  output  1  sticky overflow flag, cleared by load_start or reset

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, instruction=16'h0000, cpu_enable=0, load_count=0, load_error=0.
  - Internal write pointer=0, byte phase=LOW, held low byte=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: cpu_enable=0. load_start -> LOAD. load_end -> RUN, executing the existing RAM contents.
  - LOAD: cpu_enable=0, instruction forced to 16'h0000.
    - On load_valid in phase LOW: latch load_byte as the low byte, phase -> HIGH.
    - On load_valid in phase HIGH: write {load_byte, low} to RAM[ptr], ptr+1, load_count+1, phase -> LOW.
    - load_end -> RUN.
  - RUN: cpu_enable=1.
    - Each cycle, instruction <= RAM[IRAM_address] (1-cycle latency).
    - load_start -> LOAD, aborting execution. cpu_enable drops in the same edge.
- Priority when signals coincide in one cycle:
  - load_start beats load_end.
  - In LOAD, a load_valid byte in the same cycle as load_end is still accepted, and the byte is processed before the transition.
  - load_start + load_valid: the byte is discarded, and ptr/phase/count are cleared.
- Odd trailing byte:
  - If load_end arrives in phase HIGH, write {8'h00, low} to RAM[ptr] and increment load_count.
  - load_error is not set.
- Overflow:
  - When load_count==DEPTH, further bytes are dropped and load_error=1 (sticky).
  - ptr does not wrap, so location 0 is never overwritten.
- load_count is 9 bits so that it can represent DEPTH=256.
- Writes use a single write port. A read in the same cycle as a write is impossible, because reads occur only in RUN.
- Reset mid-load: contents written so far remain in RAM. State -> IDLE; a subsequent load_end runs the partial program.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'b00, LOAD=2'b01, RUN=2'b10
  - IRAM_DEPTH and INSTR_WIDTH constants, which the PC and the other blocks already use
- Sub-module iram_mem (synchronous 1R1W RAM, registered read, no reset on the array) keeps the inferable memory separate from the load FSM.

Test Plan:
1. Reset then load:
   - Stimulus: reset; load_start; bytes 34,12,78,56; load_end.
   - Required: load_count=2, cpu_enable=1.
   - Then IRAM_address=0 -> instruction=16'h1234 next cycle; IRAM_address=1 -> 16'h5678.
2. Odd byte:
   - Stimulus: load_start; bytes AB,CD,EF; load_end.
   - Required: RAM[1]=16'h00EF, load_count=2, load_error=0.
3. Overflow:
   - Stimulus: 514 bytes (257 words).
   - Required: load_count=256, load_error=1, RAM[0] unchanged from the first word.
   - Then load_start -> load_error=0.
4. Reload during RUN:
   - Stimulus: load_start while running.
   - Required: cpu_enable=0 at the next edge, instruction=16'h0000 throughout LOAD, load_count=0.
5. Asynchronous reset mid-load:
   - Stimulus: assert reset between clock edges after 3 bytes.
   - Required: outputs reach reset values immediately.
   - Then load_end alone -> RUN, and RAM[0] returns the previously written word.
6. Same-cycle events:
   - Stimulus: load_valid together with load_end in phase HIGH.
   - Required: the word is committed and load_count increments before RUN.
   - Stimulus: load_start together with load_valid.
   - Required: the byte is discarded.

Source files
------------

// File: rtl/iram_loader_pkg.sv
// Shared IRAM definitions: FSM state encoding and instruction store geometry.
package iram_loader_pkg;

    localparam int unsigned IRAM_DEPTH  = 256;
    localparam int unsigned INSTR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

endpackage

// File: rtl/iram_mem.sv
// Synchronous 1R1W instruction RAM; the array is never reset, the read register is.
module iram_mem #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register clears whenever the fetch side is not running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Boot loader FSM for the instruction RAM: assembles host bytes into words,
// then serves registered instruction fetches once the CPU is released.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = INSTR_WIDTH,
    parameter int unsigned DEPTH      = IRAM_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] IRAM_address,
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_end,
    output logic                  cpu_enable,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_error
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic                  phase_high;
    logic [7:0]            low_byte;
    logic                  full;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_en;

    // The word count doubles as the write pointer; it saturates at DEPTH so
    // location 0 is never revisited.
    always_comb begin
        we    = 1'b0;
        wdata = '0;
        full  = (load_count == FULL_COUNT);
        rd_en = (state == RUN) && !load_start;
        if (state == LOAD && !load_start && !full) begin
            if (load_valid && phase_high) begin
                we    = 1'b1;
                wdata = {load_byte, low_byte};
            end else if (load_end && load_valid) begin
                we    = 1'b1;
                wdata = {8'h00, load_byte};
            end else if (load_end && phase_high) begin
                we    = 1'b1;
                wdata = {8'h00, low_byte};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cpu_enable <= 1'b0;
            load_count <= '0;
            load_error <= 1'b0;
            phase_high <= 1'b0;
            low_byte   <= '0;
        end else if (load_start) begin
            // load_start wins over everything, including a coincident byte.
            state      <= LOAD;
            cpu_enable <= 1'b0;
            load_count <= '0;
            load_error <= 1'b0;
            phase_high <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_end) begin
                        state      <= RUN;
                        cpu_enable <= 1'b1;
                    end
                end
                LOAD: begin
                    if (we) begin
                        load_count <= load_count + 1'b1;
                    end
                    if (load_valid && full) begin
                        load_error <= 1'b1;
                    end
                    if (load_valid && !full && !phase_high) begin
                        low_byte <= load_byte;
                    end
                    if (load_end) begin
                        state      <= RUN;
                        cpu_enable <= 1'b1;
                        phase_high <= 1'b0;
                    end else if (load_valid && !full) begin
                        phase_high <= !phase_high;
                    end
                end
                RUN: begin
                    cpu_enable <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    cpu_enable <= 1'b0;
                end
            endcase
        end
    end

    iram_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (load_count[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .rd_en (rd_en),
        .raddr (IRAM_address),
        .rdata (instruction)
    );

endmodule
